// File: rtl/rq_wr_req_gen_pkg.sv
`default_nettype none
// ============================================================================
// Package  : rq_wr_req_gen_pkg
// Brief    : Shared types, request-type codes and descriptor field offsets
//            for the RQ write-request generator.
// Revision : 1.0 - initial release
// ============================================================================
package rq_wr_req_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    XFER  = 2'd2,
    DRAIN = 2'd3
  } rq_state_e;

  localparam logic [3:0] c_REQ_MEM_WR = 4'b0001;

  localparam int unsigned c_DESC_W   = 128;
  localparam int unsigned c_DATA_W   = 256;
  localparam int unsigned c_DWCNT_W  = 11;
  localparam int unsigned c_LEN_W    = 19;
  localparam int unsigned c_BEAT_W   = 6;

  localparam int unsigned c_DESC_ADDR_LSB  = 2;
  localparam int unsigned c_DESC_ADDR_MSB  = 63;
  localparam int unsigned c_DESC_DWCNT_LSB = 64;
  localparam int unsigned c_DESC_DWCNT_MSB = 74;
  localparam int unsigned c_DESC_TYPE_LSB  = 75;
  localparam int unsigned c_DESC_TYPE_MSB  = 78;
  localparam int unsigned c_DESC_REQID_LSB = 80;
  localparam int unsigned c_DESC_REQID_MSB = 95;
  localparam int unsigned c_DESC_TAG_LSB   = 96;
  localparam int unsigned c_DESC_TAG_MSB   = 103;
  localparam int unsigned c_DESC_LBE_LSB   = 104;
  localparam int unsigned c_DESC_LBE_MSB   = 107;
  localparam int unsigned c_DESC_FBE_LSB   = 108;
  localparam int unsigned c_DESC_FBE_MSB   = 111;

  // A single-DW TLP carries all its enables in first_be.
  function automatic logic [3:0] f_last_be(input logic [c_DWCNT_W-1:0] i_dw_cnt);
    return (i_dw_cnt > 11'd1) ? 4'hF : 4'h0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rq_wr_req_gen_if.sv
`default_nettype none
// ============================================================================
// Interface : rq_wr_req_gen_if
// Brief     : Command, payload-in and RQ-out bundle of the write generator.
// Revision  : 1.0 - initial release
// ============================================================================
interface rq_wr_req_gen_if;

  logic         cmd_valid;
  logic         cmd_ready;
  logic [63:0]  cmd_addr;
  logic [18:0]  cmd_len_dw;

  logic         din_valid;
  logic         din_ready;
  logic [255:0] din_data;

  logic [127:0] descriptor;
  logic [255:0] rq_wr_data;
  logic [10:0]  rq_dword_count;
  logic         rq_valid;
  logic         rq_sop;
  logic         rq_last;
  logic         rq_ready;
  logic         cmd_done;

  modport master (
    output cmd_valid, cmd_addr, cmd_len_dw,
    output din_valid, din_data,
    output rq_ready,
    input  cmd_ready, din_ready,
    input  descriptor, rq_wr_data, rq_dword_count,
    input  rq_valid, rq_sop, rq_last, cmd_done
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len_dw,
    input  din_valid, din_data,
    input  rq_ready,
    output cmd_ready, din_ready,
    output descriptor, rq_wr_data, rq_dword_count,
    output rq_valid, rq_sop, rq_last, cmd_done
  );

endinterface
`default_nettype wire

// File: rtl/rq_wr_req_gen_desc_pack.sv
`default_nettype none
// ============================================================================
// Module   : rq_desc_pack
// Brief    : Combinational RQ memory-write descriptor builder.
// Revision : 1.0 - initial release
// ============================================================================
module rq_desc_pack
  import rq_wr_req_gen_pkg::*;
(
  input  logic [61:0]            i_addr_dw,
  input  logic [c_DWCNT_W-1:0]   i_chunk,
  input  logic [7:0]             i_tag,
  input  logic [15:0]            i_req_id,
  output logic [c_DESC_W-1:0]    o_desc
);

  always_comb begin
    o_desc = '0;
    o_desc[c_DESC_ADDR_MSB:c_DESC_ADDR_LSB]   = i_addr_dw;
    o_desc[c_DESC_DWCNT_MSB:c_DESC_DWCNT_LSB] = i_chunk;
    o_desc[c_DESC_TYPE_MSB:c_DESC_TYPE_LSB]   = c_REQ_MEM_WR;
    o_desc[c_DESC_REQID_MSB:c_DESC_REQID_LSB] = i_req_id;
    o_desc[c_DESC_TAG_MSB:c_DESC_TAG_LSB]     = i_tag;
    o_desc[c_DESC_LBE_MSB:c_DESC_LBE_LSB]     = f_last_be(i_chunk);
    o_desc[c_DESC_FBE_MSB:c_DESC_FBE_LSB]     = 4'hF;
  end

endmodule
`default_nettype wire

// File: rtl/rq_wr_req_gen.sv
`default_nettype none
// ============================================================================
// Module   : rq_wr_req_gen
// Brief    : Splits host write commands into RQ memory-write TLPs of at most
//            MAX_PAYLOAD_DW DWs. Define RQ_WR_REQ_GEN_4K_SPLIT_EN to also
//            break TLPs at 4KB address boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module rq_wr_req_gen
  import rq_wr_req_gen_pkg::*;
#(
  parameter int MAX_PAYLOAD_DW = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [15:0]         i_cfg_req_id,
  rq_wr_req_gen_if.slave      if_rq
);

  rq_state_e              r_state;
  logic [61:0]            r_addr_dw;
  logic [c_LEN_W-1:0]     r_rem;
  logic [7:0]             r_tag;
  logic [c_DWCNT_W-1:0]   r_chunk;
  logic [c_BEAT_W-1:0]    r_beat;
  logic [c_BEAT_W-1:0]    r_last_beat;
  logic [c_DESC_W-1:0]    r_desc;
  logic                   r_cmd_ready;
  logic                   r_cmd_done;

  logic [c_LEN_W-1:0]     w_chunk_lim;
  logic [c_DWCNT_W-1:0]   w_chunk;
  logic [c_BEAT_W-1:0]    w_last_idx;
  logic [c_LEN_W-1:0]     w_rem_next;
  logic [c_DESC_W-1:0]    w_desc;
  logic                   w_in_xfer;
  logic                   w_beat_xfer;
  logic [1:0]             w_unused_addr_lsb;

  assign w_unused_addr_lsb = if_rq.cmd_addr[1:0];

  always_comb begin
    w_chunk_lim = c_LEN_W'(MAX_PAYLOAD_DW);
`ifdef RQ_WR_REQ_GEN_4K_SPLIT_EN
    begin : b_4k_limit
      logic [c_DWCNT_W-1:0] w_to_4k_dw;
      // DWs left before the next 4KB page: 1..1024
      w_to_4k_dw = 11'd1024 - {1'b0, r_addr_dw[9:0]};
      if (c_LEN_W'(w_to_4k_dw) < w_chunk_lim) begin
        w_chunk_lim = c_LEN_W'(w_to_4k_dw);
      end
    end
`endif
    w_chunk = (r_rem < w_chunk_lim) ? c_DWCNT_W'(r_rem) : c_DWCNT_W'(w_chunk_lim);
  end

  assign w_last_idx  = c_BEAT_W'((w_chunk - 11'd1) >> 3);
  assign w_rem_next  = r_rem - c_LEN_W'(r_chunk);
  assign w_in_xfer   = (r_state == XFER);
  assign w_beat_xfer = w_in_xfer && if_rq.din_valid && if_rq.rq_ready;

  rq_desc_pack u_desc_pack (
    .i_addr_dw (r_addr_dw),
    .i_chunk   (w_chunk),
    .i_tag     (r_tag),
    .i_req_id  (i_cfg_req_id),
    .o_desc    (w_desc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_addr_dw   <= '0;
      r_rem       <= '0;
      r_tag       <= '0;
      r_chunk     <= '0;
      r_beat      <= '0;
      r_last_beat <= '0;
      r_desc      <= '0;
      r_cmd_ready <= 1'b1;
      r_cmd_done  <= 1'b0;
    end else begin
      r_cmd_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (if_rq.cmd_valid && r_cmd_ready) begin
            r_addr_dw   <= if_rq.cmd_addr[63:2];
            r_rem       <= if_rq.cmd_len_dw;
            r_cmd_ready <= 1'b0;
            r_state     <= CALC;
          end
        end
        CALC: begin
          r_chunk     <= w_chunk;
          r_last_beat <= w_last_idx;
          r_desc      <= w_desc;
          r_beat      <= '0;
          r_state     <= XFER;
        end
        XFER: begin
          if (w_beat_xfer) begin
            if (r_beat == r_last_beat) begin
              r_state <= DRAIN;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        DRAIN: begin
          // Leave only once the gearbox is accepting again.
          if (if_rq.rq_ready) begin
            r_addr_dw <= r_addr_dw + 62'(r_chunk);
            r_rem     <= w_rem_next;
            r_tag     <= r_tag + 8'd1;
            if (w_rem_next == '0) begin
              r_cmd_done  <= 1'b1;
              r_cmd_ready <= 1'b1;
              r_state     <= IDLE;
            end else begin
              r_state <= CALC;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign if_rq.cmd_ready      = r_cmd_ready;
  assign if_rq.cmd_done       = r_cmd_done;
  assign if_rq.descriptor     = r_desc;
  assign if_rq.rq_dword_count = r_chunk;
  assign if_rq.rq_valid       = w_in_xfer && if_rq.din_valid;
  assign if_rq.din_ready      = w_in_xfer && if_rq.rq_ready;
  assign if_rq.rq_wr_data     = w_in_xfer ? if_rq.din_data : '0;
  assign if_rq.rq_sop         = w_in_xfer && (r_beat == '0);
  assign if_rq.rq_last        = w_in_xfer && (r_beat == r_last_beat);

endmodule
`default_nettype wire

// File: tb/tb_rq_wr_req_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_rq_wr_req_gen
// Brief    : Self-checking bench for rq_wr_req_gen with a TLP-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rq_wr_req_gen;

  localparam int MPS = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [15:0]  cfg_req_id = 16'h0;

  int           n_asrt = 0;
  int           n_fail = 0;
  logic [7:0]   exp_tag = 8'h0;
  logic [255:0] cur_data = '0;
  logic [127:0] q_desc[$];
  int           q_cnt[$];

  rq_wr_req_gen_if ifc ();

  rq_wr_req_gen #(.MAX_PAYLOAD_DW(MPS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_cfg_req_id (cfg_req_id),
    .if_rq        (ifc)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [255:0] obs, input logic [255:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // TLP size from the command rules: min(remaining, MPS, DWs to 4KB page end)
  function automatic int model_chunk(input logic [63:0] a, input int rem);
    int c;
    c = (rem < MPS) ? rem : MPS;
`ifdef RQ_WR_REQ_GEN_4K_SPLIT_EN
    begin
      int to4k;
      to4k = (4096 - int'(a[11:0])) / 4;
      if (to4k < c) c = to4k;
    end
`endif
    return c;
  endfunction

  function automatic logic [127:0] exp_desc(input logic [63:0] a, input int c,
                                            input logic [7:0] t, input logic [15:0] id);
    logic [127:0] d;
    d = '0;
    d[63:2]    = a[63:2];
    d[74:64]   = 11'(c);
    d[78:75]   = 4'b0001;
    d[95:80]   = id;
    d[103:96]  = t;
    d[107:104] = (c > 1) ? 4'hF : 4'h0;
    d[111:108] = 4'hF;
    return d;
  endfunction

  task automatic issue_cmd(input logic [63:0] addr, input int len);
    int g;
    g = 0;
    @(negedge clk);
    while (ifc.cmd_ready !== 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("cmd_ready_idle", ifc.cmd_ready, 1'b1);
    ifc.cmd_valid  = 1'b1;
    ifc.cmd_addr   = addr;
    ifc.cmd_len_dw = 19'(len);
    @(negedge clk);
    ifc.cmd_valid  = 1'b0;
    ifc.cmd_addr   = {$urandom(), $urandom()};
    ifc.cmd_len_dw = 19'($urandom());
    #1;
    chk("cmd_ready_busy", ifc.cmd_ready, 1'b0);
  endtask

  // pv < 0 toggles din_valid every cycle; drain_lo < 0 picks 0..3 stall cycles.
  task automatic run_cmd(input logic [63:0] addr, input int len, input int pv,
                         input int pr, input int drain_lo);
    logic [63:0]  a;
    logic [127:0] ed;
    int           rem, c, nb, beat, g, lo;
    bit           dv, rr;
    q_desc.delete();
    q_cnt.delete();
    a   = {addr[63:2], 2'b00};
    rem = len;
    cfg_req_id = 16'($urandom());
    issue_cmd(addr, len);
    while (rem > 0) begin
      c    = model_chunk(a, rem);
      nb   = (c + 7) / 8;
      ed   = exp_desc(a, c, exp_tag, cfg_req_id);
      beat = 0;
      g    = 0;
      while (beat < nb) begin
        @(negedge clk);
        dv = (pv < 0) ? bit'(g % 2) : ($urandom_range(0, 99) < pv);
        rr = ($urandom_range(0, 99) < pr);
        ifc.din_valid = dv;
        ifc.rq_ready  = rr;
        ifc.din_data  = cur_data;
        #1;
        chk("rq_valid", ifc.rq_valid, dv);
        chk("din_ready", ifc.din_ready, rr);
        chk("rq_sop", ifc.rq_sop, beat == 0);
        chk("rq_last", ifc.rq_last, beat == nb - 1);
        chk("dword_count", ifc.rq_dword_count, c);
        chk("descriptor", ifc.descriptor, ed);
        chk("cmd_done_busy", ifc.cmd_done, 1'b0);
        if (dv && rr) begin
          chk("rq_wr_data", ifc.rq_wr_data, cur_data);
          if (beat == 0) begin
            q_desc.push_back(ifc.descriptor);
            q_cnt.push_back(int'(ifc.rq_dword_count));
          end
          beat++;
          cur_data = rnd256();
        end
        g++;
      end
      lo = (drain_lo < 0) ? int'($urandom_range(0, 3)) : drain_lo;
      for (int i = 0; i < lo; i++) begin
        @(negedge clk);
        ifc.din_valid = 1'b1;
        ifc.rq_ready  = 1'b0;
        #1;
        chk("drain_rq_valid", ifc.rq_valid, 1'b0);
        chk("drain_din_ready", ifc.din_ready, 1'b0);
        chk("drain_count", ifc.rq_dword_count, c);
        chk("drain_desc", ifc.descriptor, ed);
        chk("drain_cmd_done", ifc.cmd_done, 1'b0);
      end
      @(negedge clk);
      ifc.din_valid = 1'b1;
      ifc.rq_ready  = 1'b1;
      #1;
      chk("drain_exit_rq_valid", ifc.rq_valid, 1'b0);
      chk("drain_exit_din_ready", ifc.din_ready, 1'b0);
      chk("drain_exit_count", ifc.rq_dword_count, c);
      a   = a + 64'(c) * 64'd4;
      rem = rem - c;
      exp_tag = exp_tag + 8'd1;
      @(negedge clk);
      #1;
      chk("post_drain_rq_valid", ifc.rq_valid, 1'b0);
      chk("post_drain_din_ready", ifc.din_ready, 1'b0);
      chk("cmd_done", ifc.cmd_done, rem == 0);
    end
    ifc.din_valid = 1'b0;
    ifc.rq_ready  = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, ifc.cmd_ready, 1'b1);
    chk({tag, "_rq_valid"}, ifc.rq_valid, 1'b0);
    chk({tag, "_din_ready"}, ifc.din_ready, 1'b0);
    chk({tag, "_sop_last"}, {ifc.rq_sop, ifc.rq_last}, 2'b00);
    chk({tag, "_desc"}, ifc.descriptor, 128'h0);
    chk({tag, "_count"}, ifc.rq_dword_count, 11'h0);
    chk({tag, "_data"}, ifc.rq_wr_data, 256'h0);
    chk({tag, "_cmd_done"}, ifc.cmd_done, 1'b0);
  endtask

  initial begin
    logic [63:0] addr;
    int          len, off;
    logic [7:0]  tbase;

    ifc.cmd_valid  = 1'b0;
    ifc.cmd_addr   = '0;
    ifc.cmd_len_dw = '0;
    ifc.din_valid  = 1'b1;
    ifc.din_data   = rnd256();
    ifc.rq_ready   = 1'b1;
    cur_data       = rnd256();

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    ifc.din_valid = 1'b0;
    ifc.rq_ready  = 1'b0;

    // Single-beat TLP
    run_cmd(64'h1000, 4, 100, 100, 0);
    chk("s1_ntlp", q_cnt.size(), 1);
    chk("s1_count", q_cnt[0], 4);
    chk("s1_tag", q_desc[0][103:96], 8'h00);
    chk("s1_last_be", q_desc[0][107:104], 4'hF);

    // MPS split: 64,64,64,8
    tbase = exp_tag;
    run_cmd(64'h2_0000, 200, 80, 80, -1);
    chk("s2_ntlp", q_cnt.size(), 4);
    for (int i = 0; i < q_cnt.size() && i < 4; i++) begin
      chk("s2_count", q_cnt[i], (i < 3) ? 64 : 8);
      chk("s2_addr", q_desc[i][63:0], 64'h2_0000 + 64'(i) * 64'h100);
      chk("s2_tag", q_desc[i][103:96], tbase + 8'(i));
      chk("s2_last_be", q_desc[i][107:104], 4'hF);
    end

`ifdef RQ_WR_REQ_GEN_4K_SPLIT_EN
    run_cmd(64'hFC0, 64, 100, 100, 0);
    chk("s3_ntlp", q_cnt.size(), 2);
    if (q_cnt.size() == 2) begin
      chk("s3_count0", q_cnt[0], 16);
      chk("s3_addr0", q_desc[0][63:0], 64'hFC0);
      chk("s3_count1", q_cnt[1], 48);
      chk("s3_addr1", q_desc[1][63:0], 64'h1000);
    end
`endif

    // Drain held by rq_ready low for 3 cycles
    run_cmd(64'h3_0040, 13, 100, 100, 3);
    chk("s4_count", q_cnt[0], 13);

    // din_valid toggling across a full-size TLP
    run_cmd(64'h4_0000, 64, -1, 100, 1);
    chk("s5_ntlp", q_cnt.size(), 1);
    chk("s5_count", q_cnt[0], 64);

    // Single-DW TLP
    run_cmd(64'h5_0007, 1, 100, 100, 0);
    chk("s6_count", q_cnt[0], 1);
    chk("s6_first_be", q_desc[0][111:108], 4'hF);
    chk("s6_last_be", q_desc[0][107:104], 4'h0);
    chk("s6_addr", q_desc[0][63:0], 64'h5_0004);

    // Random commands kept inside one 4KB page
    for (int n = 0; n < 12; n++) begin
      len  = int'($urandom_range(1, 300));
      off  = int'($urandom_range(0, 1024 - len));
      addr = {$urandom(), $urandom()};
      addr[11:0] = {10'(off), 2'($urandom())};
      run_cmd(addr, len, int'($urandom_range(40, 100)), int'($urandom_range(40, 100)), -1);
    end

    // Reset in the middle of a TLP
    issue_cmd(64'h6_0000, 64);
    repeat (3) begin
      @(negedge clk);
      ifc.din_valid = 1'b1;
      ifc.rq_ready  = 1'b1;
      ifc.din_data  = rnd256();
    end
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_tag = 8'h00;
    ifc.din_valid = 1'b0;
    ifc.rq_ready  = 1'b0;

    run_cmd(64'h1000, 4, 100, 100, 0);
    chk("s7_tag_after_reset", q_desc[0][103:96], 8'h00);
    chk("s7_count", q_cnt[0], 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
